// File: rtl/zx_pkg.sv
// Shared definitions for the Spectrum video RAM arbiter slice: VRAM geometry,
// ULA port decode and the CPU access state encoding.
package zx_pkg;

  localparam int          VRAM_ADDR_W    = 13;
  localparam logic [12:0] VRAM_ATTR_BASE = 13'h1800;
  localparam logic [7:0]  ULA_PORT_MASK  = 8'h01;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    ACK     = 2'd2
  } arb_state_e;

  // The ULA answers every even I/O address.
  function automatic logic is_ula_port(input logic [7:0] addr);
    return (addr & ULA_PORT_MASK) == 8'h00;
  endfunction

endpackage

// File: rtl/zx_port_fe.sv
// Port 0xFE output latch: border colour, tape MIC and beeper bits.
module zx_port_fe
  import zx_pkg::*;
#(
  parameter logic [2:0] BORDER_RST = 3'd7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       io_wr,
  input  logic [7:0] io_addr,
  input  logic [4:0] wdata,
  output logic [2:0] border,
  output logic       mic,
  output logic       beeper
);

  logic [2:0] border_q;
  logic       mic_q;
  logic       beeper_q;

  // Latch the ULA output bits on an I/O write that decodes to the ULA.
  always_ff @(posedge clk) begin
    if (reset) begin
      border_q <= BORDER_RST;
      mic_q    <= 1'b0;
      beeper_q <= 1'b0;
    end else if (io_wr && is_ula_port(io_addr)) begin
      border_q <= wdata[2:0];
      mic_q    <= wdata[3];
      beeper_q <= wdata[4];
    end else begin
      border_q <= border_q;
      mic_q    <= mic_q;
      beeper_q <= beeper_q;
    end
  end

  assign border = border_q;
  assign mic    = mic_q;
  assign beeper = beeper_q;

endmodule

// File: rtl/zx_vram_arbiter.sv
// Single-port VRAM arbiter: video scan-out has absolute priority, the Z80 is
// served through a req/ack handshake in the gaps. Also hosts the 0xFE latch.
module zx_vram_arbiter
  import zx_pkg::*;
#(
  parameter int          ADDR_W     = VRAM_ADDR_W,
  parameter logic [15:0] CPU_BASE   = 16'h4000,
  parameter logic [2:0]  BORDER_RST = 3'd7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              video_req,
  input  logic [ADDR_W-1:0] video_addr,
  output logic [7:0]        video_data,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [15:0]       cpu_addr,
  input  logic [7:0]        cpu_din,
  output logic [7:0]        cpu_dout,
  output logic              cpu_ack,
  input  logic              io_wr,
  input  logic [7:0]        io_addr,
  output logic [2:0]        border,
  output logic              mic,
  output logic              beeper,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  input  logic [7:0]        mem_rdata
);

  arb_state_e        st_q;
  logic              cpu_ack_q;
  logic [7:0]        cpu_dout_q;
  logic              vcap_q;
  logic [7:0]        video_data_q;
  logic [ADDR_W-1:0] mem_addr_q;

  logic [ADDR_W-1:0] cpu_word_s;
  logic              cpu_issue_s;
  logic [ADDR_W-1:0] mem_addr_d;
  logic              mem_we_d;

  assign cpu_word_s  = ADDR_W'(cpu_addr - CPU_BASE);
  assign cpu_issue_s = (st_q == IDLE) && cpu_req && !video_req;

  // RAM port issue: the address must reach the RAM in the request cycle, so
  // this path is combinational; it parks on the last address when idle.
  always_comb begin
    mem_addr_d = mem_addr_q;
    mem_we_d   = 1'b0;
    if (reset) begin
      mem_addr_d = {ADDR_W{1'b0}};
    end else if (video_req) begin
      mem_addr_d = video_addr;
    end else if (cpu_issue_s) begin
      mem_addr_d = cpu_word_s;
      mem_we_d   = cpu_we;
    end else begin
      mem_addr_d = mem_addr_q;
    end
  end

  // CPU access FSM plus the two independent read-capture registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      st_q         <= IDLE;
      cpu_ack_q    <= 1'b0;
      cpu_dout_q   <= 8'h00;
      vcap_q       <= 1'b0;
      video_data_q <= 8'h00;
      mem_addr_q   <= {ADDR_W{1'b0}};
    end else begin
      vcap_q     <= video_req;
      mem_addr_q <= mem_addr_d;
      if (vcap_q) begin
        video_data_q <= mem_rdata;
      end else begin
        video_data_q <= video_data_q;
      end
      cpu_ack_q <= 1'b0;
      case (st_q)
        IDLE: begin
          if (cpu_issue_s) begin
            st_q      <= cpu_we ? ACK : RD_WAIT;
            cpu_ack_q <= cpu_we;
          end else begin
            st_q <= IDLE;
          end
        end
        // Data here belongs to the CPU address issued last cycle, whatever
        // video does to the port this cycle.
        RD_WAIT: begin
          cpu_dout_q <= mem_rdata;
          st_q       <= ACK;
          cpu_ack_q  <= 1'b1;
        end
        ACK: begin
          st_q <= IDLE;
        end
        default: begin
          st_q <= IDLE;
        end
      endcase
    end
  end

  assign video_data = video_data_q;
  assign cpu_dout   = cpu_dout_q;
  assign cpu_ack    = cpu_ack_q;
  assign mem_addr   = mem_addr_d;
  assign mem_we     = mem_we_d;
  assign mem_wdata  = cpu_din;

  zx_port_fe #(
    .BORDER_RST (BORDER_RST)
  ) u_port_fe (
    .clk     (clk),
    .reset   (reset),
    .io_wr   (io_wr),
    .io_addr (io_addr),
    .wdata   (cpu_din[4:0]),
    .border  (border),
    .mic     (mic),
    .beeper  (beeper)
  );

endmodule

// File: tb/tb_zx_vram_arbiter.sv
// Scoreboard bench for zx_vram_arbiter with a registered-read RAM model.
module tb_zx_vram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        video_req;
  logic [12:0] video_addr;
  logic [7:0]  video_data;
  logic        cpu_req;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_din;
  logic [7:0]  cpu_dout;
  logic        cpu_ack;
  logic        io_wr;
  logic [7:0]  io_addr;
  logic [2:0]  border;
  logic        mic;
  logic        beeper;
  logic [12:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic [7:0]  mem_rdata;

  int checks = 0;
  int errors = 0;

  logic [7:0] ram     [8192];
  logic [7:0] exp_mem [8192];

  typedef struct {
    int         due;
    logic [7:0] val;
  } vexp_t;
  vexp_t      vq[$];
  logic [7:0] cq[$];

  int         ncyc = 0;
  int         ack_cnt = 0;
  int         we_cnt = 0;
  logic [12:0] last_we_addr;
  logic [7:0]  last_we_data;
  logic [7:0]  last_vexp = 8'h00;

  always #20 clk = ~clk;

  zx_vram_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .video_req  (video_req),
    .video_addr (video_addr),
    .video_data (video_data),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_din    (cpu_din),
    .cpu_dout   (cpu_dout),
    .cpu_ack    (cpu_ack),
    .io_wr      (io_wr),
    .io_addr    (io_addr),
    .border     (border),
    .mic        (mic),
    .beeper     (beeper),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_rdata  (mem_rdata)
  );

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Registered-read single-port RAM.
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  // Monitor on the falling edge: video scoreboard, ack and write counters.
  always @(negedge clk) begin
    ncyc++;
    while (vq.size() > 0 && vq[0].due == ncyc) begin
      check_eq("video_data", video_data, vq[0].val);
      last_vexp = vq[0].val;
      void'(vq.pop_front());
    end
    if (video_req && !reset) vq.push_back('{ncyc + 2, exp_mem[video_addr]});
    if (cpu_ack) ack_cnt++;
    if (mem_we) begin
      we_cnt++;
      last_we_addr = mem_addr;
      last_we_data = mem_wdata;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [12:0] word_of(input logic [15:0] a);
    logic [15:0] d;
    d = a - 16'h4000;
    return d[12:0];
  endfunction

  // One CPU access with optional concurrent video requests in cycles
  // vstart..vstart+nvid-1 (the request cycle is cycle 1).
  task automatic cpu_op(input logic we, input logic [15:0] addr, input logic [7:0] din,
                        input int vstart, input int nvid, input logic [12:0] vbase,
                        input int exp_lat, input string tag);
    int n;
    logic [12:0] w;
    w = word_of(addr);
    if (we) exp_mem[w] = din;
    else    cq.push_back(exp_mem[w]);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_din = din;
    n = 1;
    video_req  = (n >= vstart) && (n < vstart + nvid);
    video_addr = vbase + 13'(n - vstart);
    tick();
    n = 2;
    video_req  = (n >= vstart) && (n < vstart + nvid);
    video_addr = vbase + 13'(n - vstart);
    while (!cpu_ack && n < 40) begin
      tick();
      n++;
      video_req  = (n >= vstart) && (n < vstart + nvid);
      video_addr = vbase + 13'(n - vstart);
    end
    check_eq({tag, "_lat"}, n, exp_lat);
    if (!we && cq.size() > 0) begin
      if (cpu_ack) check_eq({tag, "_dout"}, cpu_dout, cq[0]);
      void'(cq.pop_front());
    end
    cpu_req = 1'b0; video_req = 1'b0;
    tick();
  endtask

  initial begin
    int acks;
    int we0;
    logic prev;
    logic ack_twice;
    for (int i = 0; i < 8192; i++) begin
      ram[i]     = 8'(i * 7 + (i >> 8) + 3);
      exp_mem[i] = 8'(i * 7 + (i >> 8) + 3);
    end
    reset = 1'b1; video_req = 1'b0; video_addr = 13'h0000;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h4001; cpu_din = 8'h55;
    io_wr = 1'b0; io_addr = 8'h00;
    tick(); tick();
    check_eq("rst_ack_cnt", ack_cnt, 0);
    check_eq("rst_we_cnt", we_cnt, 0);
    check_eq("rst_border", border, 3'd7);
    check_eq("rst_mic_beeper", {mic, beeper}, 2'b00);
    check_eq("rst_video_data", video_data, 8'h00);
    check_eq("rst_cpu_dout", cpu_dout, 8'h00);
    check_eq("rst_mem_addr", mem_addr, 13'h0000);
    reset = 1'b0; cpu_req = 1'b0;
    tick();

    // Uncontended write then read back.
    we0 = we_cnt;
    cpu_op(1'b1, 16'h4005, 8'hA5, 0, 0, 13'h0000, 2, "wr");
    check_eq("wr_we_cnt", we_cnt - we0, 1);
    check_eq("wr_we_addr", last_we_addr, 13'h0005);
    check_eq("wr_we_data", last_we_data, 8'hA5);
    cpu_op(1'b0, 16'h4005, 8'h00, 0, 0, 13'h0000, 3, "rd");

    // Video burst of 5 delays a pending read to cycle 8.
    cpu_op(1'b0, 16'h4123, 8'h00, 1, 5, 13'h0200, 8, "vprio");
    // Video collides with the RD_WAIT cycle.
    cpu_op(1'b0, 16'h5800, 8'h00, 2, 1, 13'h0000, 3, "coll");
    // Back-to-back video alone, then hold check.
    for (int i = 0; i < 6; i++) begin
      video_req = 1'b1; video_addr = 13'h1A00 + 13'(i * 3);
      tick();
    end
    video_req = 1'b0;
    tick(); tick(); tick();
    check_eq("video_hold", video_data, last_vexp);

    // Port 0xFE latch.
    io_wr = 1'b1; io_addr = 8'hFE; cpu_din = 8'h1A;
    tick();
    io_wr = 1'b0; cpu_din = 8'h00;
    check_eq("fe_border", border, 3'b010);
    check_eq("fe_mic_beeper", {mic, beeper}, 2'b11);
    io_wr = 1'b1; io_addr = 8'hFF; cpu_din = 8'h05;
    tick();
    io_wr = 1'b0;
    tick();
    check_eq("fe_odd_border", border, 3'b010);
    check_eq("fe_odd_bits", {mic, beeper}, 2'b11);
    io_wr = 1'b1; io_addr = 8'hFE; cpu_din = 8'h05;
    tick();
    io_wr = 1'b0;
    check_eq("fe2_border", border, 3'b101);
    check_eq("fe2_bits", {mic, beeper}, 2'b00);

    // Held request across three write completions.
    acks = 0; prev = 1'b0; ack_twice = 1'b0; we0 = we_cnt;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h4010; cpu_din = 8'h3C;
    exp_mem[13'h0010] = 8'h3C;
    for (int i = 0; i < 20 && acks < 3; i++) begin
      tick();
      if (cpu_ack && prev) ack_twice = 1'b1;
      if (cpu_ack) acks++;
      prev = cpu_ack;
      if (acks == 3) cpu_req = 1'b0;
    end
    cpu_req = 1'b0;
    tick(); tick(); tick();
    check_eq("held_acks", acks, 3);
    check_eq("held_no_double", ack_twice, 1'b0);
    check_eq("held_we_cnt", we_cnt - we0, 3);

    // Reset during RD_WAIT drops the access.
    acks = ack_cnt;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h4040;
    tick();
    cpu_req = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0;
    tick(); tick(); tick();
    check_eq("rst_mid_ack", ack_cnt - acks, 0);
    check_eq("rst_mid_border", border, 3'd7);

    tick(); tick();
    check_eq("vq_drain", vq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/zx_vram_arbiter.md
Name: zx_vram_arbiter

Overview:
- Owns the single port of the 8 KB Spectrum video RAM block (screen bitmap 0x0000–0x17FF, attributes 0x1800–0x1AFF in the 13-bit space).
- Shares that port between the video scan-out stage (read-only, absolute priority) and the Z80 bus (read/write, req/ack handshake with wait).
- Also holds the port 0xFE output latch: border colour, MIC and beeper.
- Sits directly upstream of the video generator; feeds its video_data and border inputs.

Parameters:
ADDR_W, 13, VRAM word address width
CPU_BASE, 16'h4000, Z80 address mapped to VRAM word 0
BORDER_RST, 3'd7, border colour after reset

Ports:
clk  in  1  system clock, 25 MHz pixel clock
reset  in  1  synchronous, active-high reset
video_req  in  1  video fetch request for this cycle
video_addr  in  13  video fetch address, sampled with video_req
video_data  out  8  last video fetch result, held until next fetch
cpu_req  in  1  CPU VRAM access request; level, held until cpu_ack
cpu_we  in  1  1 = write, 0 = read; stable while cpu_req
cpu_addr  in  16  Z80 address; stable while cpu_req
cpu_din  in  8  Z80 write data
cpu_dout  out  8  read data, valid in the cpu_ack cycle and held after
cpu_ack  out  1  one-cycle completion pulse
io_wr  in  1  Z80 I/O write strobe, one cycle
io_addr  in  8  low I/O address byte
border  out  3  border colour {G,R,B}
mic  out  1  tape MIC bit
beeper  out  1  speaker bit
mem_addr  out  13  RAM address
mem_wdata  out  8  RAM write data
mem_we  out  1  RAM write enable
mem_rdata  in  8  RAM registered read data, valid 1 cycle after address

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: video_data=0, cpu_dout=0, cpu_ack=0, mem_we=0, mem_addr=0, border=BORDER_RST, mic=0, beeper=0, FSM=IDLE.
- Reset mid-access discards the access: no ack is issued, and a write not yet driven to mem_we is not performed.
- Port-issue rule, evaluated each cycle:
  - If video_req=1: drive mem_addr=video_addr, mem_we=0, and mark a video capture for the next cycle.
  - Otherwise, if the FSM grants the CPU: drive the CPU operation.
  - Otherwise: mem_we=0, and mem_addr holds its previous value.
- Video latency: request at cycle T gives video_data=mem_rdata captured at the end of T+1, valid from T+2. video_data is unchanged in cycles with no video fetch.
- Video fetches are never delayed or dropped, including back-to-back requests every cycle.
- CPU word address = (cpu_addr - CPU_BASE) truncated to ADDR_W. No range check; the upstream decoder asserts cpu_req only inside the window.
- FSM states:
  - IDLE: cpu_req=1 and video_req=0 issues the access this cycle.
    - Write: mem_we=1, mem_wdata=cpu_din, go to ACK.
    - Read: go to RD_WAIT.
    - If video_req=1, stay in IDLE (CPU stalls).
  - RD_WAIT: capture mem_rdata into cpu_dout, go to ACK. This is independent of video_req in this cycle; a video issue here does not corrupt the capture because capture uses the previous cycle's address.
  - ACK: cpu_ack=1 for this one cycle, go to IDLE. A new request is not accepted before the cycle after ACK, even if cpu_req stays high.
- CPU latency with no video contention: write ack 2 cycles after cpu_req rises, read ack 3 cycles after. Each cycle with video_req high in IDLE adds one cycle.
- The video capture pipeline and the CPU read capture are independent registers. Both may complete in the same cycle.
- Port 0xFE latch: when io_wr=1 and io_addr[0]=0, load border<=cpu_din[2:0], mic<=cpu_din[3], beeper<=cpu_din[4]. Outputs change the following cycle. io_wr is independent of the VRAM FSM.

Decomposition:
- Shared package zx_pkg: VRAM_ADDR_W=13, VRAM_ATTR_BASE=13'h1800, ULA_PORT_MASK, and an FSM state enum {IDLE, RD_WAIT, ACK}.
- One natural sub-module: zx_port_fe, holding the 0xFE decode and the border/mic/beeper latch.
- The arbiter FSM and the capture pipelines stay in the top module.

Test Plan:
- Reset: assert reset for 2 cycles with cpu_req=1 → cpu_ack never pulses, border=3'd7, no mem_we pulse.
- Uncontended write then read: write 0x4005 data 0xA5 → mem_we=1 at mem_addr=13'h0005, ack 2 cycles after request. Read 0x4005 → ack 3 cycles after request, cpu_dout=0xA5.
- Video priority: video_req=1 for 5 consecutive cycles while a CPU read is pending → CPU issue delayed 5 cycles, ack at cycle 8. Each video_data equals RAM contents of its address 2 cycles after its request, in order.
- Collision in RD_WAIT: CPU read of 0x5800 issued; video_req=1 at 13'h0000 in the RD_WAIT cycle → cpu_dout = attr byte at 13'h1800, video_data = byte at 13'h0000, both correct.
- Port 0xFE: io_wr with io_addr=0xFE and cpu_din=0x1A → border=3'b010, mic=1, beeper=1. io_addr=0xFF → no change.
- Held request: cpu_req kept high across 3 write completions → exactly 3 single-cycle acks, each followed by at least one non-ack cycle.
